// File: rtl/mem_port_arbiter_if.sv
// Secondary bus master handshake (DMA / UART loader) into the RAM arbiter.
// master = the requester, slave = mem_port_arbiter.
interface mem_port_arbiter_if;
    logic        iDmaReq;
    logic        iDmaWe;
    logic [31:0] iDmaAddr;
    logic [31:0] iDmaWData;
    logic        oDmaAck;
    logic        oDmaErr;
    logic [31:0] oDmaRData;
    logic        oDmaStarve;

    modport master (
        output iDmaReq, iDmaWe, iDmaAddr, iDmaWData,
        input  oDmaAck, oDmaErr, oDmaRData, oDmaStarve
    );

    modport slave (
        input  iDmaReq, iDmaWe, iDmaAddr, iDmaWData,
        output oDmaAck, oDmaErr, oDmaRData, oDmaStarve
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM arbiter: the non-stallable core owns the RAM whenever
// it touches the RAM window; the secondary master is served through a
// registered req/ack handshake in the cycles the core leaves free.
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       iCpuAddr,
    input  logic              iCpuRead,
    input  logic              iCpuWrite,
    input  logic [31:0]       iCpuWData,
    output logic [31:0]       oCpuRData,
    mem_port_arbiter_if.slave dma,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic              oRamWe,
    output logic [31:0]       oRamWData,
    input  logic [31:0]       iRamRData
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              latchWe;
    logic              latchInWin;
    logic [ADDR_W-1:0] latchIdx;
    logic [31:0]       latchWData;
    logic [7:0]        starveCnt;

    logic              cpuInWin;
    logic              reqInWin;
    logic              cpuOwn;
    logic              dmaGrant;
    logic [ADDR_W-1:0] cpuIdx;
    logic [ADDR_W-1:0] reqIdx;
    logic [1:0]        unusedAddrBits;

    // Byte-lane bits are irrelevant for a word-wide RAM.
    assign unusedAddrBits = iCpuAddr[1:0] ^ dma.iDmaAddr[1:0];

    assign cpuInWin = (iCpuAddr[31:ADDR_W+2] == '0);
    assign reqInWin = (dma.iDmaAddr[31:ADDR_W+2] == '0);
    assign cpuIdx   = iCpuAddr[ADDR_W+1:2];
    assign reqIdx   = dma.iDmaAddr[ADDR_W+1:2];

    // Read and write together is treated as a write by the RAM (oRamWe = iCpuWrite).
    assign cpuOwn   = cpuInWin & (iCpuRead | iCpuWrite);
    assign dmaGrant = (state == PEND) & ~cpuOwn;

    // RAM port mux: core first, then a granted secondary access, else parked on the core address.
    always_comb begin
        oRamAddr  = cpuIdx;
        oRamWe    = 1'b0;
        oRamWData = iCpuWData;
        if (cpuOwn) begin
            oRamWe = iCpuWrite;
        end else if (dmaGrant) begin
            oRamAddr  = latchIdx;
            oRamWe    = latchWe & latchInWin;
            oRamWData = latchWData;
        end
    end

    // Core read data is gated so the top-level peripheral mux can OR sources together.
    assign oCpuRData = cpuOwn ? iRamRData : 32'd0;

    // Handshake FSM with registered ack/err/rdata/starve outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            latchWe        <= 1'b0;
            latchInWin     <= 1'b1;
            latchIdx       <= '0;
            latchWData     <= 32'd0;
            starveCnt      <= 8'd0;
            dma.oDmaAck    <= 1'b0;
            dma.oDmaErr    <= 1'b0;
            dma.oDmaRData  <= 32'd0;
            dma.oDmaStarve <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dma.oDmaAck <= 1'b0;
                    dma.oDmaErr <= 1'b0;
                    if (dma.iDmaReq) begin
                        // Freeze the request; later changes on iDma* are ignored.
                        latchWe        <= dma.iDmaWe;
                        latchInWin     <= reqInWin;
                        latchIdx       <= reqIdx;
                        latchWData     <= dma.iDmaWData;
                        starveCnt      <= 8'd0;
                        dma.oDmaStarve <= 1'b0;
                        state          <= PEND;
                    end
                end
                PEND: begin
                    if (!cpuOwn) begin
                        if (latchInWin) begin
                            if (!latchWe) begin
                                dma.oDmaRData <= iRamRData;
                            end
                            dma.oDmaErr <= 1'b0;
                        end else begin
                            dma.oDmaRData <= 32'd0;
                            dma.oDmaErr   <= 1'b1;
                        end
                        dma.oDmaAck <= 1'b1;
                        state       <= DONE;
                    end else if (starveCnt != LIMIT) begin
                        // Saturating blocked-cycle count; the flag is status only.
                        starveCnt      <= starveCnt + 8'd1;
                        dma.oDmaStarve <= ((starveCnt + 8'd1) == LIMIT);
                    end
                end
                DONE: begin
                    dma.oDmaAck <= 1'b0;
                    dma.oDmaErr <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized core
// and requester traffic, all checked against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 8;
    localparam int LIMIT  = 4;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       iCpuAddr = 32'd0;
    logic              iCpuRead = 1'b0;
    logic              iCpuWrite = 1'b0;
    logic [31:0]       iCpuWData = 32'd0;
    logic [31:0]       oCpuRData;
    logic [ADDR_W-1:0] oRamAddr;
    logic              oRamWe;
    logic [31:0]       oRamWData;
    logic [31:0]       iRamRData;

    mem_port_arbiter_if dif();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .iCpuAddr  (iCpuAddr),
        .iCpuRead  (iCpuRead),
        .iCpuWrite (iCpuWrite),
        .iCpuWData (iCpuWData),
        .oCpuRData (oCpuRData),
        .dma       (dif),
        .oRamAddr  (oRamAddr),
        .oRamWe    (oRamWe),
        .oRamWData (oRamWData),
        .iRamRData (iRamRData)
    );

    always #5 clk = ~clk;

    // The physical RAM: asynchronous read, write on rising edge.
    logic [31:0] ram [WORDS];
    assign iRamRData = ram[oRamAddr];
    always @(posedge clk) if (oRamWe) ram[oRamAddr] <= oRamWData;

    int nAsserts = 0;
    int nFails   = 0;
    int cycleNo  = 0;

    // Reference model: expected memory contents plus the one outstanding transaction.
    logic [31:0] shadow [WORDS];
    bit          shadowValid [WORDS];
    bit          txnOpen;
    bit          ackNow;
    bit          tWe;
    logic [31:0] tAddr;
    logic [31:0] tWData;
    int          blocked;
    logic [31:0] mRData;
    bit          mErr;

    function automatic bit inWin(input logic [31:0] a);
        return a[31:ADDR_W+2] == '0;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        txnOpen = 0;
        ackNow  = 0;
        blocked = 0;
        mRData  = 32'd0;
        mErr    = 0;
    endtask

    // Advance the model across one rising edge using the inputs of the ending cycle.
    task automatic modelEdge();
        bit own;
        own = inWin(iCpuAddr) && (iCpuRead || iCpuWrite);
        if (!reset) begin
            modelReset();
            return;
        end
        if (own && iCpuWrite) begin
            shadow[idx(iCpuAddr)]      = iCpuWData;
            shadowValid[idx(iCpuAddr)] = 1;
        end
        if (ackNow) begin
            ackNow = 0;
        end else if (txnOpen) begin
            if (!own) begin
                txnOpen = 0;
                ackNow  = 1;
                if (inWin(tAddr)) begin
                    mErr = 0;
                    if (tWe) begin
                        shadow[idx(tAddr)]      = tWData;
                        shadowValid[idx(tAddr)] = 1;
                    end else begin
                        mRData = shadow[idx(tAddr)];
                    end
                end else begin
                    mErr   = 1;
                    mRData = 32'd0;
                end
            end else if (blocked < LIMIT) begin
                blocked++;
            end
        end else if (dif.iDmaReq) begin
            txnOpen = 1;
            tWe     = dif.iDmaWe;
            tAddr   = dif.iDmaAddr;
            tWData  = dif.iDmaWData;
            blocked = 0;
        end
    endtask

    task automatic checkComb();
        bit own;
        int ci;
        own = inWin(iCpuAddr) && (iCpuRead || iCpuWrite);
        ci  = idx(iCpuAddr);
        if (own) begin
            check("ramAddrCpu", 32'(oRamAddr), 32'(ci));
            check("ramWeCpu", 32'(oRamWe), 32'(iCpuWrite));
            if (iCpuWrite) check("ramWDataCpu", oRamWData, iCpuWData);
            if (shadowValid[ci]) check("cpuRData", oCpuRData, shadow[ci]);
        end else begin
            check("cpuRDataGated", oCpuRData, 32'd0);
            if (txnOpen && !ackNow) begin
                if (inWin(tAddr)) begin
                    check("ramAddrDma", 32'(oRamAddr), 32'(idx(tAddr)));
                    check("ramWeDma", 32'(oRamWe), 32'(tWe));
                    if (tWe) check("ramWDataDma", oRamWData, tWData);
                end else begin
                    check("ramWeOutOfWin", 32'(oRamWe), 32'd0);
                end
            end else begin
                check("ramAddrPark", 32'(oRamAddr), 32'(ci));
                check("ramWePark", 32'(oRamWe), 32'd0);
            end
        end
    endtask

    task automatic checkRegs();
        check("dmaAck", 32'(dif.oDmaAck), 32'(ackNow));
        if (ackNow) check("dmaErr", 32'(dif.oDmaErr), 32'(mErr));
        check("dmaRData", dif.oDmaRData, mRData);
        check("dmaStarve", 32'(dif.oDmaStarve), 32'(blocked == LIMIT));
    endtask

    // One clock cycle: inputs are already driven; check, cross the edge, check again.
    task automatic cyc();
        #1;
        checkComb();
        @(posedge clk);
        modelEdge();
        cycleNo++;
        #1;
        checkRegs();
        if (ackNow)
            $display("txn: we=%0d addr=%h wdata=%h err=%0d rdata=%h starve=%0d cycle=%0d",
                     tWe, tAddr, tWData, dif.oDmaErr, dif.oDmaRData, dif.oDmaStarve, cycleNo);
    endtask

    task automatic coreSet(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        iCpuRead  = rd;
        iCpuWrite = wr;
        iCpuAddr  = a;
        iCpuWData = d;
    endtask

    task automatic coreIdle();
        coreSet(0, 0, 32'($urandom_range(0, 1023)), $urandom);
    endtask

    task automatic coreInWinAccess();
        bit wr;
        wr = 1'($urandom_range(0, 1));
        coreSet(~wr, wr, 32'($urandom_range(0, 1023)), $urandom);
    endtask

    task automatic coreRandom();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 3)      coreIdle();
        else if (k <= 5) coreSet(1, 0, 32'($urandom_range(0, 1023)), $urandom);
        else if (k <= 7) coreSet(0, 1, 32'($urandom_range(0, 1023)), $urandom);
        else if (k == 8) coreSet(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 $urandom | 32'h4000_0000, $urandom);
        else             coreSet(1, 1, 32'($urandom_range(0, 1023)), $urandom);
    endtask

    task automatic dmaStart(input bit we, input logic [31:0] a, input logic [31:0] d);
        dif.iDmaReq   = 1;
        dif.iDmaWe    = we;
        dif.iDmaAddr  = a;
        dif.iDmaWData = d;
    endtask

    task automatic newFields();
        dif.iDmaWe    = 1'($urandom_range(0, 1));
        dif.iDmaAddr  = ($urandom_range(0, 6) == 0) ? ($urandom | 32'h8000_0000)
                                                    : 32'($urandom_range(0, 1023));
        dif.iDmaWData = $urandom;
    endtask

    task automatic scrambleFields();
        dif.iDmaWe    = 1'($urandom_range(0, 1));
        dif.iDmaAddr  = $urandom;
        dif.iDmaWData = $urandom;
    endtask

    task automatic waitAck(input bit scramble, output int lat);
        lat = 0;
        do begin
            cyc();
            lat++;
            if (scramble && !dif.oDmaAck) scrambleFields();
        end while (!dif.oDmaAck && lat < 20);
        check("ackWithinBudget", 32'(dif.oDmaAck), 32'd1);
    endtask

    // Hold req through the ack cycle, then drop it.
    task automatic dmaFinish();
        cyc();
        dif.iDmaReq = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ackCyc [4];
        logic [31:0] valA;
        logic [31:0] valB;
        int stable;
        bit dropNext;

        for (int i = 0; i < WORDS; i++) shadowValid[i] = 0;
        dif.iDmaReq   = 0;
        dif.iDmaWe    = 0;
        dif.iDmaAddr  = 32'd0;
        dif.iDmaWData = 32'd0;
        modelReset();

        // Reset state.
        @(posedge clk);
        #1;
        checkRegs();
        checkComb();
        cyc();
        reset = 1;

        // Preload every RAM word through the core port.
        for (int i = 0; i < WORDS; i++) begin
            coreSet(0, 1, (32'(i) << 2) | 32'($urandom_range(0, 3)), $urandom);
            cyc();
        end
        coreIdle();

        // Idle core: secondary write then read of 0x10.
        dmaStart(1, 32'h10, 32'hDEADBEEF);
        waitAck(1, lat);
        check("wrLatency", 32'(lat), 32'd2);
        check("wrErr", 32'(dif.oDmaErr), 32'd0);
        dmaFinish();
        dmaStart(0, 32'h10, $urandom);
        waitAck(1, lat);
        check("rdLatency", 32'(lat), 32'd2);
        check("rdData", dif.oDmaRData, 32'hDEADBEEF);
        dmaFinish();

        // Core blocks a pending read for 5 cycles, then reads outside the window.
        dmaStart(0, 32'h10, 32'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            coreInWinAccess();
            cyc();
            check("blockedNoAck", 32'(dif.oDmaAck), 32'd0);
        end
        coreSet(1, 0, 32'h4000_0000, 32'd0);
        cyc();
        check("grantAfterBlock", 32'(dif.oDmaAck), 32'd1);
        check("blockedRdData", dif.oDmaRData, shadow[4]);
        coreIdle();
        dmaFinish();

        // Starvation flag across 6 blocked cycles.
        dmaStart(1, 32'h44, $urandom);
        cyc();
        for (int k = 1; k <= 6; k++) begin
            coreSet(0, 1, 32'($urandom_range(0, 1023)), $urandom);
            cyc();
            check("starveRise", 32'(dif.oDmaStarve), 32'(k >= LIMIT));
        end
        coreIdle();
        cyc();
        check("starveAtAck", 32'(dif.oDmaStarve), 32'd1);
        dmaFinish();
        check("starveIdle", 32'(dif.oDmaStarve), 32'd1);
        dmaStart(0, 32'h44, 32'd0);
        cyc();
        check("starveCleared", 32'(dif.oDmaStarve), 32'd0);
        waitAck(1, lat);
        dmaFinish();

        // Out-of-window secondary write.
        dmaStart(1, 32'h4000_0010, $urandom);
        waitAck(1, lat);
        check("oowLatency", 32'(lat), 32'd2);
        check("oowErr", 32'(dif.oDmaErr), 32'd1);
        check("oowRData", dif.oDmaRData, 32'd0);
        dmaFinish();

        // Asynchronous reset mid-cycle while PEND with starvation flagged.
        dmaStart(0, 32'h80, 32'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            coreInWinAccess();
            cyc();
        end
        #3;
        reset = 0;
        modelReset();
        coreIdle();
        dif.iDmaReq = 0;
        #1;
        check("rstMidAck", 32'(dif.oDmaAck), 32'd0);
        check("rstMidStarve", 32'(dif.oDmaStarve), 32'd0);
        check("rstMidRData", dif.oDmaRData, 32'd0);
        checkComb();
        cyc();
        cyc();
        reset = 1;
        cyc();
        cyc();
        dmaStart(1, 32'h80, $urandom);
        waitAck(1, lat);
        check("postRstLatency", 32'(lat), 32'd2);
        dmaFinish();

        // Back-to-back with req held high.
        coreIdle();
        dmaStart(1, 32'h100, $urandom);
        for (int n = 0; n < 4; n++) begin
            waitAck(0, lat);
            ackCyc[n] = cycleNo;
            if (n < 3) begin
                dif.iDmaWe    = 1'(n % 2);
                dif.iDmaAddr  = 32'h100;
                dif.iDmaWData = $urandom;
            end
        end
        dmaFinish();
        for (int n = 1; n < 4; n++)
            check("b2bSpacing", 32'(ackCyc[n] - ackCyc[n-1]), 32'd3);

        // Core sw and secondary sw to 0x20 in the same cycle: core first, secondary next.
        valA = $urandom;
        valB = ~valA;
        dmaStart(1, 32'h20, valB);
        cyc();
        coreSet(0, 1, 32'h20, valA);
        cyc();
        check("collCoreFirst", ram[8], valA);
        check("collNoAckYet", 32'(dif.oDmaAck), 32'd0);
        coreIdle();
        cyc();
        check("collAck", 32'(dif.oDmaAck), 32'd1);
        check("collRamFinal", ram[8], valB);
        dmaFinish();

        // Read-after-write: secondary read granted right after a core write.
        valA = $urandom;
        dmaStart(0, 32'h30, 32'd0);
        cyc();
        coreSet(0, 1, 32'h30, valA);
        cyc();
        coreIdle();
        cyc();
        check("rawAck", 32'(dif.oDmaAck), 32'd1);
        check("rawData", dif.oDmaRData, valA);
        dmaFinish();

        // Randomized traffic from both masters.
        stable   = 0;
        dropNext = 0;
        for (int c = 0; c < 600; c++) begin
            if (stable > 0) stable--;
            coreRandom();
            if (dif.oDmaAck) begin
                if ($urandom_range(0, 3) == 0) begin
                    newFields();
                    stable = 2;
                end else begin
                    dropNext = 1;
                end
            end else if (dropNext) begin
                dropNext    = 0;
                dif.iDmaReq = 0;
            end else if (!dif.iDmaReq) begin
                if ($urandom_range(0, 2) == 0) begin
                    newFields();
                    dif.iDmaReq = 1;
                    stable = 1;
                end
            end else if (stable == 0 && $urandom_range(0, 1) == 0) begin
                scrambleFields();
            end
            cyc();
        end
        coreIdle();
        for (int c = 0; c < 8; c++) begin
            if (dif.oDmaAck) dropNext = 1;
            else if (dropNext) begin
                dropNext    = 0;
                dif.iDmaReq = 0;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data RAM between the single-cycle core's data-memory port and one secondary bus master (DMA or UART loader). The core cannot stall, so it has absolute priority every cycle. The secondary master is served only in cycles where the core does not touch the RAM window, through a registered req/ack handshake. The block sits in the top module between the core's memory signals, the RAM, and the secondary master.

## Interface
- ADDR_W, 8: RAM word-address width; RAM window is byte addresses 0 .. 2^(ADDR_W+2)-1
- STARVE_LIMIT, 16: consecutive blocked PEND cycles before starvation is flagged (1..255)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low
- iCpuAddr  in  32  core byte address
- iCpuRead  in  1  core memory read
- iCpuWrite  in  1  core memory write
- iCpuWData  in  32  core write data
- oCpuRData  out  32  RAM read data to core; combinational
- iDmaReq  in  1  secondary request; held until oDmaAck
- iDmaWe  in  1  1 = write, 0 = read
- iDmaAddr  in  32  secondary byte address
- iDmaWData  in  32  secondary write data
- oDmaAck  out  1  one-cycle completion pulse
- oDmaErr  out  1  valid with oDmaAck; address outside the RAM window
- oDmaRData  out  32  registered read data; valid from the ack cycle until the next ack
- oDmaStarve  out  1  blocked count has reached STARVE_LIMIT
- oRamAddr  out  ADDR_W  RAM word address
- oRamWe  out  1  RAM write enable; RAM writes on rising edge
- oRamWData  out  32  RAM write data
- iRamRData  in  32  RAM asynchronous read data

## Operation
- **Window test.** in_win(a) = (a[31:ADDR_W+2] == 0). The word index is a[ADDR_W+1:2]. a[1:0] is ignored.
- **Core ownership (cpu_own).** cpu_own = in_win(iCpuAddr) & (iCpuRead | iCpuWrite). Read and write both high counts as a write.
- **RAM port mux (combinational).**
  - cpu_own: oRamAddr from iCpuAddr, oRamWe = iCpuWrite, oRamWData = iCpuWData.
  - Else if dma_grant: oRamAddr from the latched address, oRamWe = latched we, oRamWData = latched wdata.
  - Else: oRamAddr from iCpuAddr, oRamWe = 0.
- **Core read data.** oCpuRData = iRamRData when cpu_own, else 0. The top module muxes peripheral data separately.
- **FSM states.** IDLE, PEND, DONE.
- **IDLE.** If iDmaReq = 1, latch iDmaWe, iDmaAddr and iDmaWData, clear the starve counter, and go to PEND.
- **PEND.**
  - dma_grant = ~cpu_own.
  - Granted, in-window: the write happens in the RAM this cycle; a read captures iRamRData into oDmaRData at the edge. Go to DONE with err = 0.
  - Granted, out of window: no RAM access (oRamWe = 0), oDmaRData := 0, go to DONE with err = 1.
  - Not granted: stay in PEND; starve counter +1, saturating at STARVE_LIMIT.
- **DONE.** oDmaAck = 1 and oDmaErr = the latched err, for exactly this cycle. The next state is IDLE unconditionally.
- **Requester rule.** The requester drops iDmaReq in the cycle after it sees the ack. A req still high in IDLE is treated as a new transaction.
- **Starvation flag.** oDmaStarve = (count == STARVE_LIMIT). It clears when the counter clears on the next IDLE latch. It stays asserted through DONE. It is status only and never preempts the core.
- **Latched fields.** The latched request fields are frozen during PEND and DONE. iDma* changes during PEND are ignored.

## Timing
- **Reset (asynchronous, immediate).**
  - state = IDLE, starve count = 0, latched fields = 0, err = 0.
  - oDmaAck = 0, oDmaErr = 0, oDmaRData = 0, oDmaStarve = 0.
  - oRamWe follows the combinational rule, so it is 0 unless the core writes in window.
  - A pending transaction is dropped with no ack.
- **Core latency.** Zero cycles. The core sees the RAM exactly as if directly connected.
- **Secondary latency.**
  - Minimum: request in IDLE at edge N, grant in PEND during cycle N+1, ack during cycle N+2.
  - Each blocked PEND cycle adds one cycle.
- **Write collision.** A core write and a secondary write in the same cycle is impossible. The core wins, and the secondary write retries next cycle.
- **Read-after-write.** A secondary read granted the cycle after a core write to the same word returns the new value.
- **Throughput.** Maximum secondary throughput is one transaction per 3 cycles.

## Test plan
- **Idle core, secondary write then read.** Core idle; secondary writes 0xDEADBEEF to byte address 0x10, then reads 0x10. Ack 2 cycles after each req edge, oRamWe high only in the PEND cycle, oDmaRData = 0xDEADBEEF, oDmaErr = 0.
- **Core blocking the secondary.**
  - Core issues lw/sw in window for 5 consecutive cycles while a secondary read is pending.
  - Required: no secondary RAM access during those cycles, core data is correct, and the grant lands in the first cycle the core is idle or accessing 0x40000000.
- **Starvation flag.** With STARVE_LIMIT = 4, block the secondary for 6 cycles. oDmaStarve rises after the 4th blocked cycle, holds through ack, and is 0 after the next IDLE latch.
- **Out-of-window secondary write.** Secondary writes to address 0x40000010. No oRamWe pulse; ack with oDmaErr = 1 and oDmaRData = 0.
- **Reset mid-transaction.** Assert reset in PEND, asynchronously and mid-cycle. Outputs go to reset values immediately, no ack is ever produced, and a new request after release completes normally.
- **Back-to-back and simultaneous.**
  - Keep iDmaReq high continuously: transactions complete every 3 cycles.
  - Core sw to 0x20 in the same cycle a secondary write to 0x20 is granted: RAM ends holding the secondary value, written one cycle later.
